// File: rtl/mem_port_arbiter.sv
// Shared memory port sequencer for instruction-fetch (I) and memory-stage (D) requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin conflict resolution; default is fixed D priority.
module mem_port_arbiter #(
  parameter int unsigned N   = 32,
  parameter int unsigned LAT = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic IReq,
  output logic IGnt,
  output logic IValid,
  output logic IStall,
  input  logic DReq,
  input  logic DWe,
  output logic DGnt,
  output logic DValid,
  output logic DStall,
  output logic Sel,
  output logic MemEn,
  output logic MemWe
);

  localparam int unsigned CW = $clog2(LAT) + 1;

  if (N == 0 || LAT == 0) begin : g_cfg_check
    $error("mem_port_arbiter: N and LAT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          req_any;
  logic          win_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_d;
  logic conflict;

  always_comb begin
    req_any  = IReq | DReq;
    conflict = IReq & DReq;
    win_d    = conflict ? rr_d : DReq;
  end

  // Pointer moves only on contested arbitrations, so the loser wins the next conflict.
  always_ff @(posedge Clk) begin
    if (!Reset)
      rr_d <= 1'b1;
    else if (state != ACCESS && conflict)
      rr_d <= ~rr_d;
  end
`else
  // D is the older instruction in the pipe, so it always wins a conflict.
  always_comb begin
    req_any = IReq | DReq;
    win_d   = DReq;
  end
`endif

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      Sel    <= 1'b0;
      MemEn  <= 1'b0;
      MemWe  <= 1'b0;
      IGnt   <= 1'b0;
      DGnt   <= 1'b0;
      IValid <= 1'b0;
      DValid <= 1'b0;
    end else begin
      MemEn  <= 1'b0;
      MemWe  <= 1'b0;
      IGnt   <= 1'b0;
      DGnt   <= 1'b0;
      IValid <= 1'b0;
      DValid <= 1'b0;
      case (state)
        ACCESS: begin
          if (cnt == '0) begin
            state  <= RESP;
            IValid <= ~Sel;
            DValid <= Sel;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        // IDLE and RESP both arbitrate, giving back-to-back accesses out of RESP.
        default: begin
          if (req_any) begin
            state <= ACCESS;
            Sel   <= win_d;
            MemEn <= 1'b1;
            MemWe <= win_d & DWe;
            IGnt  <= ~win_d;
            DGnt  <= win_d;
            cnt   <= CW'(LAT - 1);
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign IStall = IReq & ~IValid;
  assign DStall = DReq & ~DValid;

endmodule
